// File: rtl/program_state_stack.sv
// program_state_stack: per-context current program state with a DEPTH-entry
// LIFO save stack for nested trap entry (push) and trap return (pop).
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_ctx                    context addressed by the command and by the outputs
//   i_alter/i_push/i_pop     commands; i_ps is the new state for alter/push
//   i_clr_err                clear the sticky error of i_ctx
//   o_ps/o_depth/o_full/o_empty/o_err  combinational view of context i_ctx
module program_state_stack #(
  parameter int              PS_W     = 32,
  parameter int              NUM_CTX  = 2,
  parameter int              DEPTH    = 4,
  parameter logic [PS_W-1:0] RESET_PS = '0,
  localparam int             CTX_W    = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  localparam int             DEP_W    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [CTX_W-1:0] i_ctx,
  input  logic             i_alter,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [PS_W-1:0]  i_ps,
  input  logic             i_clr_err,
  output logic [PS_W-1:0]  o_ps,
  output logic [DEP_W-1:0] o_depth,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_err
);

  localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEP_W-1:0] DEPTH_L = DEP_W'(DEPTH);
  localparam logic [CTX_W:0]   NCTX_L  = (CTX_W + 1)'(NUM_CTX);

  logic [PS_W-1:0]  cur_q   [NUM_CTX];
  logic [PS_W-1:0]  cur_d   [NUM_CTX];
  logic [DEP_W-1:0] depth_q [NUM_CTX];
  logic [DEP_W-1:0] depth_d [NUM_CTX];
  logic             err_q   [NUM_CTX];
  logic             err_d   [NUM_CTX];
  logic [PS_W-1:0]  stack_q [NUM_CTX][DEPTH];

  logic             ctx_vld;
  logic [CTX_W-1:0] sel;
  logic [DEP_W-1:0] dep_sel;
  logic [DEP_W-1:0] dep_m1;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             stk_we;
  logic             set_err;

  // Out-of-range contexts (only possible for non-power-of-two NUM_CTX) are
  // steered to index 0 for the array reads, but all writes and outputs are
  // masked by ctx_vld so they never observe or disturb context 0.
  assign ctx_vld = ({1'b0, i_ctx} < NCTX_L);
  assign sel     = ctx_vld ? i_ctx : '0;
  assign dep_sel = depth_q[sel];
  assign dep_m1  = dep_sel - DEP_W'(1);
  assign wr_idx  = dep_sel[IDX_W-1:0];
  assign rd_idx  = dep_m1[IDX_W-1:0];

  always_comb begin
    cur_d   = cur_q;
    depth_d = depth_q;
    err_d   = err_q;
    stk_we  = 1'b0;
    set_err = 1'b0;
    if (ctx_vld) begin
      if (i_push && i_pop) begin
        set_err = 1'b1;
      end else if (i_push) begin
        if (dep_sel != DEPTH_L) begin
          stk_we       = 1'b1;
          depth_d[sel] = dep_sel + DEP_W'(1);
          cur_d[sel]   = i_ps;
        end else begin
          set_err = 1'b1;
        end
      end else if (i_pop) begin
        if (dep_sel != '0) begin
          cur_d[sel]   = stack_q[sel][rd_idx];
          depth_d[sel] = dep_m1;
        end else begin
          set_err = 1'b1;
        end
      end else if (i_alter) begin
        cur_d[sel] = i_ps;
      end
      // A new error wins over a clear requested in the same cycle.
      if (set_err) begin
        err_d[sel] = 1'b1;
      end else if (i_clr_err) begin
        err_d[sel] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        cur_q[c]   <= RESET_PS;
        depth_q[c] <= '0;
        err_q[c]   <= 1'b0;
      end
    end else begin
      cur_q   <= cur_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage carries no reset: entries at or above depth are never read.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && stk_we) begin
      stack_q[sel][wr_idx] <= cur_q[sel];
    end
  end

  assign o_ps    = ctx_vld ? cur_q[sel] : RESET_PS;
  assign o_depth = ctx_vld ? dep_sel : '0;
  assign o_full  = ctx_vld && (dep_sel == DEPTH_L);
  assign o_empty = !ctx_vld || (dep_sel == '0);
  assign o_err   = !ctx_vld || err_q[sel];

endmodule

// File: tb/tb_program_state_stack.sv
module tb_program_state_stack;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // DUT A: default parameters (2 contexts, depth 4)
  logic        a_ctx, a_alter, a_push, a_pop, a_clr;
  logic [31:0] a_ps, a_ops;
  logic [2:0]  a_depth;
  logic        a_full, a_empty, a_err;

  // DUT B: 3 contexts (non-power-of-two), depth 1
  logic [1:0]  b_ctx;
  logic        b_alter, b_push, b_pop, b_clr;
  logic [31:0] b_ps, b_ops;
  logic [0:0]  b_depth;
  logic        b_full, b_empty, b_err;

  program_state_stack dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_ctx(a_ctx), .i_alter(a_alter),
    .i_push(a_push), .i_pop(a_pop), .i_ps(a_ps), .i_clr_err(a_clr),
    .o_ps(a_ops), .o_depth(a_depth), .o_full(a_full), .o_empty(a_empty),
    .o_err(a_err)
  );

  program_state_stack #(.PS_W(32), .NUM_CTX(3), .DEPTH(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_ctx(b_ctx), .i_alter(b_alter),
    .i_push(b_push), .i_pop(b_pop), .i_ps(b_ps), .i_clr_err(b_clr),
    .o_ps(b_ops), .o_depth(b_depth), .o_full(b_full), .o_empty(b_empty),
    .o_err(b_err)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  ctx;
    logic        alter, push, pop, clr;
    logic [31:0] ps;
    logic [31:0] e_ps;
    int          e_dep;
    logic        e_full, e_empty, e_err;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(logic r, logic [1:0] c, logic al, logic pu, logic po,
                              logic cl, logic [31:0] p, logic [31:0] eps, int edep,
                              logic ef, logic ee, logic er);
    vec_t v;
    v.rst_n = r; v.ctx = c; v.alter = al; v.push = pu; v.pop = po; v.clr = cl;
    v.ps = p; v.e_ps = eps; v.e_dep = edep; v.e_full = ef; v.e_empty = ee; v.e_err = er;
    vq.push_back(v);
  endfunction

  task automatic cmp(string nm, logic [31:0] ps, int dep, logic f, logic e, logic er,
                     logic [31:0] eps, int edep, logic ef, logic ee, logic eer);
    n_vec++;
    if (ps !== eps || dep != edep || f !== ef || e !== ee || er !== eer) begin
      n_bad++;
      $display("FAIL %s: got ps=%h depth=%0d full=%b empty=%b err=%b, want ps=%h depth=%0d full=%b empty=%b err=%b",
               nm, ps, dep, f, e, er, eps, edep, ef, ee, eer);
    end
  endtask

  task automatic b_step(string nm, logic [1:0] c, logic pu, logic po, logic [31:0] p,
                        logic [31:0] eps, int edep, logic ef, logic ee, logic eer);
    @(negedge clk);
    b_ctx = c; b_push = pu; b_pop = po; b_ps = p;
    @(posedge clk);
    #1;
    cmp(nm, b_ops, int'(b_depth), b_full, b_empty, b_err, eps, edep, ef, ee, eer);
  endtask

  initial begin
    rst_n = 1'b0;
    a_ctx = 0; a_alter = 0; a_push = 0; a_pop = 0; a_clr = 0; a_ps = 0;
    b_ctx = 0; b_alter = 0; b_push = 0; b_pop = 0; b_clr = 0; b_ps = 0;

    //   rst ctx alt psh pop clr  ps        exp_ps    dep full emp err
    // reset held two cycles with push asserted
    add(0, 0, 0, 1, 0, 0, 32'hFF,   32'h0,    0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0, 32'hFF,   32'h0,    0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,    32'h0,    0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 32'h0,    32'h0,    0, 0, 1, 0);
    // nesting on ctx 0
    add(1, 0, 1, 0, 0, 0, 32'h11,   32'h11,   0, 0, 1, 0);
    add(1, 0, 0, 1, 0, 0, 32'h22,   32'h22,   1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 32'h33,   32'h33,   2, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 32'h0,    32'h22,   1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 32'h0,    32'h11,   0, 0, 1, 0);
    // context isolation
    add(1, 1, 0, 1, 0, 0, 32'h55,   32'h55,   1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,    32'h11,   0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 32'h0,    32'h55,   1, 0, 0, 0);
    // underflow, clear, set-beats-clear
    add(1, 0, 0, 0, 1, 0, 32'h0,    32'h11,   0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1, 32'h0,    32'h11,   0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 1, 32'h0,    32'h11,   0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1, 32'h0,    32'h11,   0, 0, 1, 0);
    // fill to full, then overflow
    add(1, 0, 0, 1, 0, 0, 32'hA1,   32'hA1,   1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 32'hA2,   32'hA2,   2, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 32'hA3,   32'hA3,   3, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 32'hA4,   32'hA4,   4, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0, 32'hA5,   32'hA4,   4, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1, 32'h0,    32'hA4,   4, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 32'h0,    32'h55,   1, 0, 0, 0);
    // conflict on ctx 1 with depth 1
    add(1, 1, 0, 1, 1, 0, 32'h99,   32'h55,   1, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 32'h0,    32'h55,   1, 0, 0, 0);
    // push beats alter; pop beats alter
    add(1, 1, 1, 1, 0, 0, 32'h77,   32'h77,   2, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 32'h0,    32'h55,   1, 0, 0, 0);
    add(1, 1, 1, 0, 1, 0, 32'h66,   32'h0,    0, 0, 1, 0);
    // alter under a non-empty stack, stale entry overwrite
    add(1, 0, 0, 0, 1, 0, 32'h0,    32'hA3,   3, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 32'hBB,   32'hBB,   3, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 32'h0,    32'hA2,   2, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 32'hC1,   32'hC1,   3, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 32'h0,    32'hA2,   2, 0, 0, 0);
    // reset mid-sequence, then pop is an underflow
    add(0, 0, 0, 0, 1, 0, 32'h0,    32'h0,    0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 32'h0,    32'h0,    0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0, 32'h0,    32'h0,    0, 0, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst_n = vq[i].rst_n; a_ctx = vq[i].ctx[0]; a_alter = vq[i].alter;
      a_push = vq[i].push; a_pop = vq[i].pop; a_clr = vq[i].clr; a_ps = vq[i].ps;
      @(posedge clk);
      #1;
      cmp($sformatf("vec%0d", i), a_ops, int'(a_depth), a_full, a_empty, a_err,
          vq[i].e_ps, vq[i].e_dep, vq[i].e_full, vq[i].e_empty, vq[i].e_err);
    end

    @(negedge clk);
    a_ctx = 0; a_alter = 0; a_push = 0; a_pop = 0; a_clr = 0;

    // 3-context, depth-1 instance: out-of-range context and depth-1 limits
    b_step("b_ctx3_push",   2'd3, 1, 0, 32'h5, 32'h0, 0, 0, 1, 1);
    b_step("b_ctx2_idle",   2'd2, 0, 0, 32'h0, 32'h0, 0, 0, 1, 0);
    b_step("b_ctx2_push",   2'd2, 1, 0, 32'h9, 32'h9, 1, 1, 0, 0);
    b_step("b_ctx2_ovf",    2'd2, 1, 0, 32'hA, 32'h9, 1, 1, 0, 1);
    b_step("b_ctx2_pop",    2'd2, 0, 1, 32'h0, 32'h0, 0, 0, 1, 1);
    b_step("b_ctx0_idle",   2'd0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 0);
    b_step("b_ctx1_idle",   2'd1, 0, 0, 32'h0, 32'h0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
